fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side client for the team's synchronous FIFO. It drives the FIFO read enable, never underflows, and absorbs the FIFO's fixed one-cycle read latency. Popped words are re-presented on a valid/ready stream toward the downstream consumer, with a 2-entry output buffer so full throughput survives backpressure. It sits between the FIFO's read port and any consumer that needs flow control instead of raw `o_rddata`.

## Interface
- `DATA_W`, 8: data width; must equal the FIFO's `DATA_W`.
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `i_en`  in  1: drain enable.
- `fifo_empty`  in  1: FIFO `o_empty`.
- `fifo_rddata`  in  DATA_W: FIFO `o_rddata`; valid the cycle after `fifo_rden`.
- `fifo_rden`  out  1: FIFO `i_rden`.
- `m_valid`  out  1: output word valid.
- `m_data`  out  DATA_W: output word.
- `m_ready`  in  1: consumer accepts the word.
- `o_busy`  out  1: the state machine is not in IDLE.
- `o_rd_cnt`  out  32: count of words delivered (see Configuration).

## Operation
- State machine states are IDLE, RUN and DRAIN.
  - IDLE -> RUN when `i_en`=1.
  - RUN -> DRAIN when `i_en`=0.
  - DRAIN -> IDLE when in-flight=0 and buffer occupancy=0.
  - `i_en` is ignored in DRAIN; the machine must return to IDLE before it can restart.
- `fifo_rden` is combinational and is high only when all of the following hold:
  - state is RUN;
  - `i_en`=1;
  - `fifo_empty`=0;
  - (occ + inflight − pop) < 2, where occ is buffer occupancy (0–2), inflight is a read issued last cycle (0/1), and pop = `m_valid & m_ready`.
- `fifo_rden` must never be high while `fifo_empty`=1.
- Inflight is a 1-bit register equal to last cycle's `fifo_rden`. When it is set, `fifo_rddata` is written into the 2-entry buffer at the end of that cycle.
- The buffer is FIFO-ordered.
  - `m_valid` = occ≠0.
  - `m_data` = head entry, registered.
  - On pop, the head advances.
  - A write and a pop in the same cycle leave occ unchanged and preserve order.
  - The credit rule above guarantees the buffer never overflows; no word is ever dropped or duplicated.
- `m_data` must hold stable while `m_valid`=1 and `m_ready`=0.
- `o_busy` is high in RUN and DRAIN.

## Timing
- Reset values: `fifo_rden`=0, `m_valid`=0, `m_data`=0, `o_busy`=0, `o_rd_cnt`=0, state=IDLE, occ=0, inflight=0.
- Reset applied mid-operation discards in-flight and buffered words. The FIFO shares the same `rst`, so no accounting is carried across reset.
- Startup and latency:
  - `i_en` rises in cycle t; RUN is entered at t+1.
  - The first `fifo_rden` can occur at t+1.
  - A word read in cycle r appears with `m_valid`=1 at r+2.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, `fifo_rden` is high every cycle and `m_valid` is high every cycle after fill.
- Backpressure: with `m_ready`=0, at most 2 reads are issued beyond the accepted words, then `fifo_rden` stays low.
- `i_en` falling in cycle t blocks `fifo_rden` in cycle t itself, because the gate is combinational.

## Configuration
- `FIFO_RD_CNT_EN` defined: `o_rd_cnt` increments by 1 on every pop, wraps from 0xFFFF_FFFF to 0, and is cleared only by `rst`.
- `FIFO_RD_CNT_EN` undefined: the counter logic is removed and `o_rd_cnt` is tied to 0. The port is always present.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random inputs -> all outputs equal their reset values and `fifo_rden`=0 throughout.
- Streaming: FIFO holds 0x11, 0x22, 0x33, 0x44; `i_en`=1 and `m_ready`=1 -> 4 consecutive `fifo_rden`, `m_data` 0x11..0x44 on 4 consecutive cycles, first `m_valid` 2 cycles after the first `fifo_rden`, then `o_rd_cnt`=4 (0 without the macro).
- Backpressure: same preload with `m_ready`=0 -> exactly 2 `fifo_rden`, and `m_data`=0x11 stays stable. Raising `m_ready` -> 0x11..0x44 in order, with no loss or duplication.
- Empty: `fifo_empty`=1 with `i_en`=1 for 20 cycles -> `fifo_rden` never asserts, `m_valid`=0, `o_busy`=1.
- Disable: drop `i_en` while occ=2 and `m_ready`=0 -> no further `fifo_rden` and `o_busy` stays 1. Releasing `m_ready` -> both words are delivered, then IDLE and `o_busy`=0 the following cycle.
- Reset mid-operation: assert `rst` with inflight=1 and occ=1 -> next cycle `m_valid`=0 and `o_rd_cnt`=0. The stale word never appears after reset is released.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read-side client with 2-entry valid/ready output buffer; FIFO_RD_CNT_EN enables the pop counter
module fifo_rd_stream #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rddata,
  output logic              fifo_rden,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              o_busy,
  output logic [31:0]       o_rd_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q;
  logic [DATA_W-1:0] b0_q, b0_d, b1_q, b1_d;
  logic              pop;
  logic [1:0]        wr_slot;
  logic [2:0]        credit;
  assign pop       = m_valid & m_ready;
  assign m_valid   = occ_q != 2'd0;
  assign m_data    = b0_q;
  assign o_busy    = state_q != IDLE;
  assign credit    = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign wr_slot   = occ_q - {1'b0, pop};
  // reads are gated combinationally so a falling i_en blocks the read in the same cycle
  assign fifo_rden = !rst && state_q == RUN && i_en && !fifo_empty && credit < 3'd2;
  // mode sequencing: DRAIN must empty the pipeline before returning to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_en ? RUN : IDLE;
      RUN:     state_d = i_en ? RUN : DRAIN;
      DRAIN:   state_d = (!inflight_q && occ_q == 2'd0) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // head entry shifts out on pop; returning data lands behind whatever remains
  always_comb begin
    b0_d  = pop ? b1_q : b0_q;
    b1_d  = b1_q;
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    if (inflight_q && wr_slot == 2'd0) b0_d = fifo_rddata;
    if (inflight_q && wr_slot != 2'd0) b1_d = fifo_rddata;
  end
  // state, buffer and read-latency tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rden;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  end
`ifdef FIFO_RD_CNT_EN
  logic [31:0] cnt_q;
  // delivered-word counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 32'd1;
  end
  assign o_rd_cnt = cnt_q;
`else
  assign o_rd_cnt = '0;
`endif
endmodule
